// File: rtl/udp_loop_ctrl_pkg.sv
// loop_pkg: shared types and constants for the UDP loopback controller.
//   state_t  - controller FSM encoding (IDLE, LOAD, BUSY, RELEASE)
//   DROP_MAX - saturation value of the dropped-job counter
package loop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/udp_loop_ctrl_len_fifo.sv
// len_fifo: synchronous first-word-fall-through FIFO of payload lengths.
//   sys_clk, rst - clock, asynchronous active-high reset (empties the FIFO)
//   push, din    - write request and data; ignored when full unless pop is
//                  accepted in the same cycle
//   pop, dout    - read request; dout always shows the head entry
//   count        - number of stored entries, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module len_fifo
    import loop_pkg::*;
#(
    parameter int LEN_W = 12,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [LEN_W-1:0]         din,
    output logic [LEN_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/udp_loop_ctrl.sv
// udp_loop_ctrl: queues received UDP payload lengths and replays each one as
// a tx job using a level handshake with the MAC.
//   sys_clk, rst - clock, asynchronous active-high reset
//   fd_udp_rx    - rx-done level; each rising edge enqueues rx_len
//   rx_len       - received length, valid while fd_udp_rx is high
//   fs_udp_tx    - tx-start request level, high only in BUSY
//   fd_udp_tx    - tx-done level from the MAC
//   tx_len       - length of the current tx job, stable LOAD..RELEASE
//   pend_cnt     - number of queued jobs
//   drop_cnt     - jobs dropped on a full queue, saturating
//   err_timeout  - sticky tx-timeout flag
//   fsm_state    - current controller state (debug view)
// Macro UDP_LOOP_TIMEOUT_EN: when defined, a job that waits TO_CYC cycles in
// BUSY without fd_udp_tx is abandoned and err_timeout is set; otherwise BUSY
// waits forever and err_timeout is tied low.
//
// Handshake: fs_udp_tx is a level that rises in BUSY and stays high until
// fd_udp_tx is seen high; the next request is only raised after fd_udp_tx
// has returned low.
module udp_loop_ctrl
    import loop_pkg::*;
#(
    parameter int LEN_W  = 12,
    parameter int DEPTH  = 4,
    parameter int TO_CYC = 65535
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     fd_udp_rx,
    input  logic [LEN_W-1:0]         rx_len,
    output logic                     fs_udp_tx,
    input  logic                     fd_udp_tx,
    output logic [LEN_W-1:0]         tx_len,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic [7:0]               drop_cnt,
    output logic                     err_timeout,
    output logic [1:0]               fsm_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("udp_loop_ctrl: DEPTH must be a power of 2 and at least 2");
    end
    if (TO_CYC < 2) begin : g_bad_timeout
        $error("udp_loop_ctrl: TO_CYC must be at least 2");
    end

    state_t           state;
    logic             rx_q;
    logic             rx_q2;
    logic [LEN_W-1:0] len_q;
    logic             push;
    logic             pop;
    logic             full;
    logic [LEN_W-1:0] head;

    // Edge detect runs one stage behind the input so a captured length is
    // written on the cycle after fd_udp_rx is first seen high. Both stages
    // reset to 1 so a level already high at reset release is not an edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_q  <= 1'b1;
            rx_q2 <= 1'b1;
            len_q <= '0;
        end else begin
            rx_q  <= fd_udp_rx;
            rx_q2 <= rx_q;
            if (fd_udp_rx && !rx_q) begin
                len_q <= rx_len;
            end
        end
    end

    assign push = rx_q && !rx_q2;
    assign pop  = (state == IDLE) && (pend_cnt != '0);
    assign full = (pend_cnt == CNT_W'(DEPTH));

    len_fifo #(
        .LEN_W (LEN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (len_q),
        .dout    (head),
        .count   (pend_cnt)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (push && full && !pop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef UDP_LOOP_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fs_udp_tx <= 1'b0;
            tx_len    <= '0;
`ifdef UDP_LOOP_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pend_cnt != '0) begin
                        tx_len <= head;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    state     <= BUSY;
                    fs_udp_tx <= 1'b1;
`ifdef UDP_LOOP_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (fd_udp_tx) begin
                        state     <= RELEASE;
                        fs_udp_tx <= 1'b0;
                    end
`ifdef UDP_LOOP_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                        // Abandon the job; the queue keeps draining normally.
                        state       <= IDLE;
                        fs_udp_tx   <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!fd_udp_tx) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UDP_LOOP_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    assign fsm_state = state;

endmodule

// File: tb/tb_udp_loop_ctrl.sv
// Testbench for udp_loop_ctrl: table of single jobs plus hand-written
// sequences for the full queue, reset mid-job and the timeout option.
module tb_udp_loop_ctrl;

    localparam int LEN_W  = 12;
    localparam int DEPTH  = 4;
    localparam int TO_CYC = 100;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic             sys_clk   = 1'b0;
    logic             rst       = 1'b1;
    logic             fd_udp_rx = 1'b0;
    logic [LEN_W-1:0] rx_len    = '0;
    logic             fd_udp_tx = 1'b0;
    logic             fs_udp_tx;
    logic [LEN_W-1:0] tx_len;
    logic [2:0]       pend_cnt;
    logic [7:0]       drop_cnt;
    logic             err_timeout;
    logic [1:0]       fsm_state;

    udp_loop_ctrl #(
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .TO_CYC (TO_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .fd_udp_rx   (fd_udp_rx),
        .rx_len      (rx_len),
        .fs_udp_tx   (fs_udp_tx),
        .fd_udp_tx   (fd_udp_tx),
        .tx_len      (tx_len),
        .pend_cnt    (pend_cnt),
        .drop_cnt    (drop_cnt),
        .err_timeout (err_timeout),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [LEN_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Waits (at negedges) for fs_udp_tx high; returns the cycle count seen.
    task automatic wait_fs(input string name, output int at);
        at = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (fs_udp_tx) begin
                at = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: fs_udp_tx got 0 after 300 cycles, required 1", name);
    endtask

    // One-cycle rx pulse starting at the current negedge.
    task automatic rx_pulse(input logic [LEN_W-1:0] len);
        rx_len    = len;
        fd_udp_rx = 1'b1;
        @(negedge sys_clk);
        fd_udp_rx = 1'b0;
        @(negedge sys_clk);
    endtask

    // Completes the job in BUSY: done high one cycle, then low.
    task automatic finish_job(input string name);
        fd_udp_tx = 1'b1;
        @(negedge sys_clk);
        check({name, "_fs_drop"}, 32'(fs_udp_tx), 0);
        check({name, "_release"}, 32'(fsm_state), 32'(ST_RELEASE));
        fd_udp_tx = 1'b0;
        @(negedge sys_clk);
        check({name, "_idle"}, 32'(fsm_state), 32'(ST_IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [LEN_W-1:0] len;
        int               hold;
        logic [LEN_W-1:0] exp_len;
        int               exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int at;
        int t0;
        int highs;
        int nz;

        vecs[0] = '{len: 12'd64,   hold: 1,  exp_len: 12'd64,   exp_lat: 3};
        vecs[1] = '{len: 12'd0,    hold: 1,  exp_len: 12'd0,    exp_lat: 3};
        vecs[2] = '{len: 12'd4095, hold: 2,  exp_len: 12'd4095, exp_lat: 3};
        vecs[3] = '{len: 12'd1,    hold: 20, exp_len: 12'd1,    exp_lat: 3};
        vecs[4] = '{len: 12'd2730, hold: 3,  exp_len: 12'd2730, exp_lat: 3};

        // Reset values while rst is held.
        repeat (3) @(negedge sys_clk);
        check("rst_fs",    32'(fs_udp_tx),   0);
        check("rst_txlen", 32'(tx_len),      0);
        check("rst_pend",  32'(pend_cnt),    0);
        check("rst_drop",  32'(drop_cnt),    0);
        check("rst_err",   32'(err_timeout), 0);
        check("rst_state", 32'(fsm_state),   32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single jobs from the table, including a 20-cycle held level.
        for (int i = 0; i < 5; i++) begin
            automatic int h = vecs[i].hold;
            rx_len    = vecs[i].len;
            fd_udp_rx = 1'b1;
            t0        = cyc;
            fork
                begin
                    repeat (h) @(negedge sys_clk);
                    fd_udp_rx = 1'b0;
                end
            join_none
            wait_fs($sformatf("vec%0d_wait", i), at);
            check($sformatf("vec%0d_latency", i), 32'(at - t0 - 1), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_txlen", i), 32'(tx_len), 32'(vecs[i].exp_len));
            finish_job($sformatf("vec%0d", i));
            highs = 0;
            repeat (25) begin
                @(negedge sys_clk);
                if (fs_udp_tx) highs++;
            end
            check($sformatf("vec%0d_no_repeat", i), 32'(highs), 0);
            check($sformatf("vec%0d_pend", i), 32'(pend_cnt), 0);
        end

        // Burst into a full queue while job 9 sits in BUSY.
        rx_pulse(12'd9);
        wait_fs("burst_job9", at);
        check("burst_job9_len", 32'(tx_len), 9);
        for (int k = 10; k <= 14; k++) begin
            rx_pulse(LEN_W'(k));
            if (k <= 13) exp_q.push_back(LEN_W'(k));
        end
        repeat (3) @(negedge sys_clk);
        check("burst_pend", 32'(pend_cnt), 4);
        check("burst_drop", 32'(drop_cnt), 1);

        // Finish job 9 and land a push on the same edge as the pop of 10.
        fd_udp_tx = 1'b1;
        @(negedge sys_clk);
        check("burst_fs_drop", 32'(fs_udp_tx), 0);
        fd_udp_tx = 1'b0;
        rx_len    = 12'd15;
        fd_udp_rx = 1'b1;
        @(negedge sys_clk);
        fd_udp_rx = 1'b0;
        @(negedge sys_clk);
        check("pushpop_pend",  32'(pend_cnt),  4);
        check("pushpop_drop",  32'(drop_cnt),  1);
        check("pushpop_state", 32'(fsm_state), 32'(ST_LOAD));
        exp_q.push_back(12'd15);

        for (int j = 0; j < 5; j++) begin
            wait_fs($sformatf("order%0d_wait", j), at);
            check($sformatf("order%0d_txlen", j), 32'(tx_len), 32'(exp_q.pop_front()));
            finish_job($sformatf("order%0d", j));
        end
        check("order_pend", 32'(pend_cnt), 0);
        check("order_drop", 32'(drop_cnt), 1);

        // Reset in the middle of a job with two jobs pending.
        @(negedge sys_clk);
        rx_pulse(12'd100);
        wait_fs("rst_job", at);
        rx_pulse(12'd101);
        rx_pulse(12'd102);
        check("midrst_pend_before", 32'(pend_cnt), 2);
        #2;
        rst       = 1'b1;
        fd_udp_rx = 1'b1;
        #1;
        check("midrst_fs",    32'(fs_udp_tx), 0);
        check("midrst_pend",  32'(pend_cnt),  0);
        check("midrst_txlen", 32'(tx_len),    0);
        check("midrst_drop",  32'(drop_cnt),  0);
        check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge sys_clk);
        rst = 1'b0;
        highs = 0;
        nz    = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (fs_udp_tx) highs++;
            if (pend_cnt != 0) nz++;
        end
        check("post_rst_no_job",  32'(highs), 0);
        check("post_rst_no_push", 32'(nz),    0);
        fd_udp_rx = 1'b0;
        repeat (2) @(negedge sys_clk);

        rx_pulse(12'd7);
        wait_fs("post_rst_job", at);
        check("post_rst_txlen", 32'(tx_len), 7);
        finish_job("post_rst");

`ifdef UDP_LOOP_TIMEOUT_EN
        // Timed-out job is lost; the queued job still goes out.
        @(negedge sys_clk);
        rx_pulse(12'd50);
        wait_fs("to_job", t0);
        rx_pulse(12'd51);
        at = -1;
        for (int k = 0; k < 300; k++) begin
            if (err_timeout) begin
                at = cyc;
                break;
            end
            @(negedge sys_clk);
        end
        check("to_cycles", 32'(at - t0), 32'(TO_CYC));
        check("to_fs", 32'(fs_udp_tx), 0);
        wait_fs("to_next", at);
        check("to_next_txlen", 32'(tx_len), 51);
        finish_job("to_next");
        check("to_sticky", 32'(err_timeout), 1);
`else
        // No timer: BUSY waits well past TO_CYC.
        @(negedge sys_clk);
        rx_pulse(12'd50);
        wait_fs("noto_job", at);
        repeat (150) @(negedge sys_clk);
        check("noto_err",   32'(err_timeout), 0);
        check("noto_fs",    32'(fs_udp_tx),   1);
        check("noto_state", 32'(fsm_state),   32'(ST_BUSY));
        finish_job("noto");
`endif

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
